// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: whole 16-byte L1.5 block fetches unpacked into a
// multi-push instruction FIFO, with flush-and-drop handling of redirects.
module fetch_queue_unit_chk #(
  parameter int unsigned AW = 3
) (
  input logic          clk,
  input logic          nrst,
  input logic          unpack,
  input logic [AW:0]   need,
  input logic [AW:0]   free_cnt
);
  a_no_overflow: assert property (@(posedge clk) disable iff (!nrst) !(unpack && (need > free_cnt)));
endmodule

module fetch_queue_unit #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [31:0] RESET_PC    = 32'h40000000,
  parameter logic [4:0]  RQTYPE      = 5'b00000,
  parameter bit          WAKE_ON_INT = 1'b1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        redirect_val,
  input  logic [31:0] redirect_pc,
  output logic        instr_val,
  input  logic        instr_rdy,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_misaligned,
  output logic [4:0]  transducer_l15_rqtype,
  output logic [2:0]  transducer_l15_size,
  output logic [31:0] transducer_l15_address,
  output logic [63:0] transducer_l15_data,
  output logic        transducer_l15_val,
  input  logic        l15_transducer_ack,
  input  logic        l15_transducer_header_ack,
  input  logic        l15_transducer_val,
  input  logic [63:0] l15_transducer_data_0,
  input  logic [63:0] l15_transducer_data_1,
  input  logic [3:0]  l15_transducer_returntype,
  output logic        transducer_l15_req_ack,
  output logic [1:0]  fetch_state
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {S_SLEEP = 2'd0, S_IDLE = 2'd1, S_REQ = 2'd2, S_RESP = 2'd3} state_t;
  localparam state_t RESET_STATE = WAKE_ON_INT ? S_SLEEP : S_IDLE;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  state_t      state, state_nx;
  logic [31:0] fetch_pc, pc_nx;
  logic [AW:0] wr_ptr, rd_ptr, wr_nx, rd_nx, count, free_cnt, need;
  logic        drop_pending, drop_nx, halted, halted_nx;
  logic        hdr_seen, hdr_nx, ack_seen, ack_nx, hdr_now, ack_now;
  logic        redir, misaligned_redir, resp_done, unpack, pop;
  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc    [DEPTH];
  logic [DEPTH-1:0] mem_mis;
  logic [DEPTH-1:0] we;
  logic [31:0] wd_instr  [DEPTH];
  logic [31:0] wd_pc     [DEPTH];
  logic [DEPTH-1:0] wd_mis;
  logic [31:0] resp_word [4];
  logic [AW-1:0] slot, head;
  logic        head_val, head_mis;
  logic [31:0] head_instr, head_pc;

  assign resp_word[0] = l15_transducer_data_0[63:32];
  assign resp_word[1] = l15_transducer_data_0[31:0];
  assign resp_word[2] = l15_transducer_data_1[63:32];
  assign resp_word[3] = l15_transducer_data_1[31:0];

  assign count            = wr_ptr - rd_ptr;
  assign free_cnt         = (AW+1)'(DEPTH) - count;
  assign need             = (AW+1)'(3'd4) - (AW+1)'(fetch_pc[3:2]);
  assign redir            = redirect_val && (state != S_SLEEP);
  assign misaligned_redir = redir && (redirect_pc[1:0] != 2'b00);
  assign resp_done        = (state == S_RESP) && l15_transducer_val &&
                            ((l15_transducer_returntype == 4'b0000) || (l15_transducer_returntype == 4'b0001));
  assign unpack           = resp_done && !drop_pending && !redir;
  assign pop              = instr_val && instr_rdy;
  assign hdr_now          = hdr_seen || l15_transducer_header_ack;
  assign ack_now          = ack_seen || l15_transducer_ack;

  assign transducer_l15_rqtype  = RQTYPE;
  assign transducer_l15_size    = 3'b100;
  assign transducer_l15_data    = 64'h0;
  assign transducer_l15_req_ack = (state == S_RESP) && l15_transducer_val;
  assign fetch_state            = state;

  // Control next state: handshake latching, PC advance and redirect override.
  always_comb begin
    state_nx  = state;
    pc_nx     = fetch_pc;
    drop_nx   = drop_pending;
    halted_nx = halted;
    hdr_nx    = hdr_seen;
    ack_nx    = ack_seen;
    case (state)
      S_SLEEP: begin
        if (l15_transducer_val && (l15_transducer_returntype == 4'b0111)) state_nx = S_IDLE;
        else state_nx = S_SLEEP;
      end
      S_IDLE: begin
        if (!halted && (free_cnt >= need) && !redir) state_nx = S_REQ;
        else state_nx = S_IDLE;
      end
      S_REQ: begin
        if (hdr_now && ack_now) begin
          state_nx = S_RESP;
          hdr_nx   = 1'b0;
          ack_nx   = 1'b0;
        end else begin
          hdr_nx = hdr_now;
          ack_nx = ack_now;
        end
      end
      S_RESP: begin
        if (resp_done) begin
          state_nx = S_IDLE;
          drop_nx  = 1'b0;
        end else begin
          state_nx = S_RESP;
        end
      end
      default: state_nx = RESET_STATE;
    endcase
    if (unpack) pc_nx = {fetch_pc[31:4] + 28'd1, 4'b0000};
    else pc_nx = fetch_pc;
    // A response that is still owed must be consumed before refetching.
    if (redir) begin
      pc_nx     = redirect_pc;
      halted_nx = misaligned_redir;
      if ((state == S_REQ) && (hdr_now || misaligned_redir)) drop_nx = 1'b1;
      else if ((state == S_RESP) && !resp_done) drop_nx = 1'b1;
      else drop_nx = drop_pending && !resp_done;
    end else begin
      halted_nx = halted;
    end
  end

  // FIFO write enables, pointer updates and the post-update head entry.
  always_comb begin
    we     = '0;
    wd_mis = '0;
    slot   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wd_instr[i] = 32'h0;
      wd_pc[i]    = 32'h0;
    end
    if (redir) begin
      rd_nx       = '0;
      wr_nx       = misaligned_redir ? (AW+1)'(1'b1) : '0;
      we[0]       = misaligned_redir;
      wd_instr[0] = NOP;
      wd_pc[0]    = redirect_pc;
      wd_mis[0]   = 1'b1;
    end else begin
      rd_nx = rd_ptr + (AW+1)'(pop);
      wr_nx = wr_ptr + (unpack ? need : '0);
      for (int k = 0; k < 4; k++) begin
        slot           = wr_ptr[AW-1:0] + AW'(k) - AW'(fetch_pc[3:2]);
        we[slot]       = unpack && (k >= int'(fetch_pc[3:2]));
        wd_instr[slot] = bswap(resp_word[k]);
        wd_pc[slot]    = {fetch_pc[31:4], 2'(k), 2'b00};
        wd_mis[slot]   = 1'b0;
      end
    end
    head     = rd_nx[AW-1:0];
    head_val = (wr_nx != rd_nx);
    if (we[head]) begin
      head_instr = wd_instr[head];
      head_pc    = wd_pc[head];
      head_mis   = wd_mis[head];
    end else begin
      head_instr = mem_instr[head];
      head_pc    = mem_pc[head];
      head_mis   = mem_mis[head];
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state                  <= RESET_STATE;
      fetch_pc               <= RESET_PC;
      wr_ptr                 <= '0;
      rd_ptr                 <= '0;
      drop_pending           <= 1'b0;
      halted                 <= 1'b0;
      hdr_seen               <= 1'b0;
      ack_seen               <= 1'b0;
      instr_val              <= 1'b0;
      instr                  <= 32'h0;
      instr_pc               <= 32'h0;
      instr_misaligned       <= 1'b0;
      transducer_l15_val     <= 1'b0;
      transducer_l15_address <= 32'h0;
    end else begin
      state                  <= state_nx;
      fetch_pc               <= pc_nx;
      wr_ptr                 <= wr_nx;
      rd_ptr                 <= rd_nx;
      drop_pending           <= drop_nx;
      halted                 <= halted_nx;
      hdr_seen               <= hdr_nx;
      ack_seen               <= ack_nx;
      instr_val              <= head_val;
      instr                  <= head_val ? head_instr : 32'h0;
      instr_pc               <= head_val ? head_pc : 32'h0;
      instr_misaligned       <= head_val && head_mis;
      transducer_l15_val     <= (state_nx == S_REQ);
      transducer_l15_address <= (state_nx == S_REQ) ? {pc_nx[31:4], 4'b0000} : 32'h0;
    end
  end

  // Entry storage; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we[i]) begin
        mem_instr[i] <= wd_instr[i];
        mem_pc[i]    <= wd_pc[i];
        mem_mis[i]   <= wd_mis[i];
      end
    end
  end

  fetch_queue_unit_chk #(.AW(AW)) u_chk (
    .clk      (clk),
    .nrst     (nrst),
    .unpack   (unpack),
    .need     (need),
    .free_cnt (free_cnt)
  );
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit (DEPTH=4, wake on INT_RET): wake-up,
// block unpack, backpressure, mid-block redirect, stale drop and misaligned halt.
module tb_fetch_queue_unit;
  logic        clk = 1'b0;
  logic        nrst;
  logic        redirect_val;
  logic [31:0] redirect_pc;
  logic        instr_val;
  logic        instr_rdy;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_misaligned;
  logic [4:0]  transducer_l15_rqtype;
  logic [2:0]  transducer_l15_size;
  logic [31:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;
  logic        transducer_l15_val;
  logic        l15_transducer_ack;
  logic        l15_transducer_header_ack;
  logic        l15_transducer_val;
  logic [63:0] l15_transducer_data_0;
  logic [63:0] l15_transducer_data_1;
  logic [3:0]  l15_transducer_returntype;
  logic        transducer_l15_req_ack;
  logic [1:0]  fetch_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .DEPTH(4), .RESET_PC(32'h40000000), .RQTYPE(5'b00000), .WAKE_ON_INT(1'b1)
  ) dut (
    .clk                       (clk),
    .nrst                      (nrst),
    .redirect_val              (redirect_val),
    .redirect_pc               (redirect_pc),
    .instr_val                 (instr_val),
    .instr_rdy                 (instr_rdy),
    .instr                     (instr),
    .instr_pc                  (instr_pc),
    .instr_misaligned          (instr_misaligned),
    .transducer_l15_rqtype     (transducer_l15_rqtype),
    .transducer_l15_size       (transducer_l15_size),
    .transducer_l15_address    (transducer_l15_address),
    .transducer_l15_data       (transducer_l15_data),
    .transducer_l15_val        (transducer_l15_val),
    .l15_transducer_ack        (l15_transducer_ack),
    .l15_transducer_header_ack (l15_transducer_header_ack),
    .l15_transducer_val        (l15_transducer_val),
    .l15_transducer_data_0     (l15_transducer_data_0),
    .l15_transducer_data_1     (l15_transducer_data_1),
    .l15_transducer_returntype (l15_transducer_returntype),
    .transducer_l15_req_ack    (transducer_l15_req_ack),
    .fetch_state               (fetch_state)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr);
    int n = 0;
    while ((transducer_l15_val !== 1'b1) && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    check_value({tag, "_val"}, 64'(transducer_l15_val), 64'h1);
    check_value({tag, "_addr"}, 64'(transducer_l15_address), 64'(addr));
  endtask

  task automatic ack_both();
    l15_transducer_header_ack = 1'b1;
    l15_transducer_ack        = 1'b1;
    @(negedge clk);
    l15_transducer_header_ack = 1'b0;
    l15_transducer_ack        = 1'b0;
  endtask

  task automatic respond(input string tag, input logic [3:0] rt, input logic [63:0] d0, input logic [63:0] d1);
    l15_transducer_val        = 1'b1;
    l15_transducer_returntype = rt;
    l15_transducer_data_0     = d0;
    l15_transducer_data_1     = d1;
    #1;
    check_value({tag, "_reqack"}, 64'(transducer_l15_req_ack), 64'h1);
    @(negedge clk);
    l15_transducer_val        = 1'b0;
    l15_transducer_returntype = 4'b0000;
  endtask

  task automatic check_head(input string tag, input logic [31:0] ei, input logic [31:0] ep, input logic em);
    check_value({tag, "_val"}, 64'(instr_val), 64'h1);
    check_value({tag, "_instr"}, 64'(instr), 64'(ei));
    check_value({tag, "_pc"}, 64'(instr_pc), 64'(ep));
    check_value({tag, "_mis"}, 64'(instr_misaligned), 64'(em));
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_val = 1'b1;
    redirect_pc  = pc;
    @(negedge clk);
    redirect_val = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; redirect_val = 1'b0; redirect_pc = 32'h0; instr_rdy = 1'b0;
    l15_transducer_ack = 1'b0; l15_transducer_header_ack = 1'b0; l15_transducer_val = 1'b0;
    l15_transducer_data_0 = 64'h0; l15_transducer_data_1 = 64'h0; l15_transducer_returntype = 4'b0000;
    #2;
    check_value("rst_state", 64'(fetch_state), 64'h0);
    check_value("rst_l15_val", 64'(transducer_l15_val), 64'h0);
    check_value("rst_addr", 64'(transducer_l15_address), 64'h0);
    check_value("rst_size", 64'(transducer_l15_size), 64'h4);
    check_value("rst_rqtype", 64'(transducer_l15_rqtype), 64'h0);
    check_value("rst_instr_val", 64'(instr_val), 64'h0);
    check_value("rst_req_ack", 64'(transducer_l15_req_ack), 64'h0);
    @(negedge clk);
    nrst = 1'b1;

    // Asleep: no request, and a redirect is ignored.
    redirect(32'h40000006);
    tick(3);
    check_value("sleep_state", 64'(fetch_state), 64'h0);
    check_value("sleep_noreq", 64'(transducer_l15_val), 64'h0);
    check_value("sleep_nopush", 64'(instr_val), 64'h0);

    l15_transducer_val = 1'b1; l15_transducer_returntype = 4'b0111;
    @(negedge clk);
    l15_transducer_val = 1'b0; l15_transducer_returntype = 4'b0000;
    check_value("wake_state", 64'(fetch_state), 64'h1);
    wait_req("wake", 32'h40000000);
    check_value("wake_size", 64'(transducer_l15_size), 64'h4);
    check_value("wake_rqtype", 64'(transducer_l15_rqtype), 64'h0);

    // Acks in separate cycles.
    l15_transducer_header_ack = 1'b1;
    @(negedge clk);
    l15_transducer_header_ack = 1'b0; l15_transducer_ack = 1'b1;
    check_value("split_hold", 64'(transducer_l15_val), 64'h1);
    @(negedge clk);
    l15_transducer_ack = 1'b0;
    check_value("split_state", 64'(fetch_state), 64'h3);
    check_value("split_val_low", 64'(transducer_l15_val), 64'h0);

    // Aligned block, then backpressure with a full 4-entry queue.
    respond("blk", 4'b0001, 64'h13000000_93000000, 64'h13010000_93010000);
    check_head("blk0", 32'h00000013, 32'h40000000, 1'b0);
    tick(4);
    check_head("bp_hold", 32'h00000013, 32'h40000000, 1'b0);
    check_value("bp_state", 64'(fetch_state), 64'h1);
    check_value("bp_noreq", 64'(transducer_l15_val), 64'h0);
    instr_rdy = 1'b1;
    @(negedge clk); check_head("blk1", 32'h00000093, 32'h40000004, 1'b0);
    @(negedge clk); check_head("blk2", 32'h00000113, 32'h40000008, 1'b0);
    @(negedge clk); check_head("blk3", 32'h00000193, 32'h4000000C, 1'b0);
    @(negedge clk);
    check_value("drain_empty", 64'(instr_val), 64'h0);
    check_value("drain_noreq", 64'(transducer_l15_val), 64'h0);
    @(negedge clk);
    check_value("next_val", 64'(transducer_l15_val), 64'h1);
    check_value("next_addr", 64'(transducer_l15_address), 64'h40000010);

    // Redirect before header ack retargets the pending request.
    redirect(32'h40000108);
    check_value("mid_state", 64'(fetch_state), 64'h2);
    check_value("mid_val", 64'(transducer_l15_val), 64'h1);
    check_value("mid_addr", 64'(transducer_l15_address), 64'h40000100);
    ack_both();
    check_value("mid_resp_state", 64'(fetch_state), 64'h3);
    respond("mid", 4'b0001, 64'hAABBCCDD_11223344, 64'h55667788_99AABBCC);
    check_head("mid2", 32'h88776655, 32'h40000108, 1'b0);
    @(negedge clk); check_head("mid3", 32'hCCBBAA99, 32'h4000010C, 1'b0);
    @(negedge clk); check_value("mid_empty", 64'(instr_val), 64'h0);
    wait_req("after_mid", 32'h40000110);

    // Redirect while a response is owed: response is acked and dropped.
    ack_both();
    check_value("stale_resp_state", 64'(fetch_state), 64'h3);
    redirect(32'h40000200);
    check_value("stale_state", 64'(fetch_state), 64'h3);
    check_value("stale_empty", 64'(instr_val), 64'h0);
    respond("stale", 4'b0001, 64'hDEADBEEF_DEADBEEF, 64'hDEADBEEF_DEADBEEF);
    check_value("stale_nopush", 64'(instr_val), 64'h0);
    check_value("stale_idle", 64'(fetch_state), 64'h1);
    wait_req("stale_next", 32'h40000200);

    // Fill the queue, then a misaligned redirect flushes and halts.
    instr_rdy = 1'b0;
    ack_both();
    respond("fill", 4'b0001, 64'h01020304_05060708, 64'h090A0B0C_0D0E0F10);
    check_head("fill0", 32'h04030201, 32'h40000200, 1'b0);
    tick(3);
    check_value("fill_idle", 64'(fetch_state), 64'h1);
    check_value("fill_noreq", 64'(transducer_l15_val), 64'h0);
    redirect(32'h40000006);
    check_head("mis", 32'h00000013, 32'h40000006, 1'b1);
    instr_rdy = 1'b1;
    tick(1);
    check_value("mis_pop", 64'(instr_val), 64'h0);
    tick(4);
    check_value("halt_state", 64'(fetch_state), 64'h1);
    check_value("halt_noreq", 64'(transducer_l15_val), 64'h0);
    redirect(32'h40000010);
    wait_req("resume", 32'h40000010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
